carry_select_4bit: RTL and testbench
====================================

// Module: carry_select_4bit
// PURPOSE
//   Unsigned 4-bit adder, F = A + B + cin, built as a carry-select adder.
//   The sum and carry-out are available combinationally, and a registered copy is also provided.
//   It is a leaf arithmetic block for datapaths, and it can be cascaded through cin/cout into wider adders.
// PARAMETERS
//   WIDTH  4  operand/sum width in bits; must be a multiple of BLK
//   BLK    2  carry-select block size in bits; WIDTH/BLK blocks
// PORTS
//   clk     in   1      single clock, rising edge; used only by the output register stage
//   rst     in   1      reset, synchronous, active-high
//   A       in   WIDTH  addend A, unsigned
//   B       in   WIDTH  addend B, unsigned
//   cin     in   1      carry-in
//   F       out  WIDTH  sum[WIDTH-1:0], combinational
//   cout    out  1      carry-out, i.e. sum bit WIDTH, combinational
//   F_q     out  WIDTH  F registered on clk
//   cout_q  out  1      cout registered on clk
// BEHAVIOUR
//   - Arithmetic: {cout,F} = A + B + cin, computed at WIDTH+1 bits with no truncation before the carry-out.
//     Valid range is 0..(2*(2^WIDTH-1)+1); for WIDTH=4 that is 0..31.
//   - F and cout: purely combinational with zero-cycle latency.
//     They must settle within one settling delay of any change on A, B or cin.
//     They are independent of clk and rst, and rst does not affect them.
//   - F_q and cout_q: on each rising clk edge:
//     - if rst=1, they load 0;
//     - otherwise they load the current F and cout.
//     - Latency is one cycle, and there is no enable.
//   - Reset values: F_q=0 and cout_q=0. F and cout have no reset value because they follow the inputs.
//   - Reset asserted mid-operation: the registered outputs clear on the next edge while the combinational path continues unaffected.
//     Deasserting rst resumes capture on the following edge.
//   - Boundaries:
//     - all-zero inputs give F=0, cout=0;
//     - A=B=all-ones with cin=1 gives F=all-ones, cout=1;
//     - a carry that wraps across every block boundary (e.g. 0xF+0x0+1) must give F=0, cout=1.
//   - No X propagation from unused mux legs: both speculative sums are always computed.
// STRUCTURE
//   - Block 0 (bits BLK-1:0) is a ripple adder fed directly by cin.
//   - Each higher block k holds two ripple adders, one precomputing with carry-in 0 and one with carry-in 1.
//     A 2:1 mux selects the sum bits and block carry using the actual carry out of block k-1.
//   - cout is the selected carry of the top block.
//   - Sub-module ripple_carry_block (BLK-bit ripple adder built from full adders).
//     It has ports a, b, ci, s, co and is instantiated 2*(WIDTH/BLK)-1 times.
//   - No shared package is needed. WIDTH and BLK remain local parameters of this module.
// TESTING
//   - Exhaustive combinational sweep: A, B in 0..15 and cin in {0,1}, 512 cases.
//     Require {cout,F}==A+B+cin with F checked after settle, including A=15 and B=15.
//   - A=4'b1111, B=4'b0000, cin=1 -> F=0000, cout=1, covering a ripple through all blocks.
//   - A=4'b0011, B=4'b0001, cin=0 -> F=0100, cout=0, covering a block-0 carry that selects the carry-1 leg of block 1.
//   - A=4'b1111, B=4'b1111, cin=1 -> F=1111, cout=1, the maximum value.
//   - Register path: rst=1 for 2 edges -> F_q=0 and cout_q=0. Then release rst, apply A=9, B=8, cin=0.
//     After one edge require F_q=0001 and cout_q=1.
//   - Mid-run reset: with A=7, B=5, assert rst for one edge.
//     Require F_q=0 and cout_q=0 while F stays 1100; on the next edge after release, F_q=1100.

Source files
------------

// File: rtl/ripple_carry_block.sv
// BLK-bit ripple adder built from a chain of full adders.
// Serves as both the block-0 adder and the speculative legs of the higher blocks.
module ripple_carry_block #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[W];

endmodule

// File: rtl/carry_select_4bit.sv
// Carry-select adder {cout,F} = A + B + cin with a one-cycle registered copy.
// Block 0 ripples from cin; every higher block precomputes both carry-in cases and muxes.
module carry_select_4bit #(
  parameter int WIDTH = 4,
  parameter int BLK   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] F,
  output logic             cout,
  output logic [WIDTH-1:0] F_q,
  output logic             cout_q
);

  localparam int NBLK = WIDTH / BLK;

  // Leg 0 assumes block carry-in 0, leg 1 assumes carry-in 1.
  logic [NBLK-1:0][BLK-1:0] s0, s1;
  logic [NBLK-1:0]          co0, co1;
  logic [NBLK:0]            c;

  assign c[0] = cin;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    if (k == 0) begin : g_base
      ripple_carry_block #(.W(BLK)) u_rca (
        .a (A[BLK-1:0]),
        .b (B[BLK-1:0]),
        .ci(cin),
        .s (s0[0]),
        .co(co0[0])
      );
      // Both legs alias the real result so the select below stays uniform.
      assign s1[0]  = s0[0];
      assign co1[0] = co0[0];
    end else begin : g_sel
      ripple_carry_block #(.W(BLK)) u_rca0 (
        .a (A[k*BLK +: BLK]),
        .b (B[k*BLK +: BLK]),
        .ci(1'b0),
        .s (s0[k]),
        .co(co0[k])
      );
      ripple_carry_block #(.W(BLK)) u_rca1 (
        .a (A[k*BLK +: BLK]),
        .b (B[k*BLK +: BLK]),
        .ci(1'b1),
        .s (s1[k]),
        .co(co1[k])
      );
    end

    assign F[k*BLK +: BLK] = c[k] ? s1[k]  : s0[k];
    assign c[k+1]          = c[k] ? co1[k] : co0[k];
  end

  assign cout = c[NBLK];

  always_ff @(posedge clk) begin
    if (rst) begin
      F_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      F_q    <= F;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_carry_select_4bit.sv
// Self-checking bench: arithmetic model checked every cycle plus directed literal vectors.
module tb_carry_select_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] A = '0, B = '0;
  logic       cin = 1'b0;
  logic [3:0] F, F_q;
  logic       cout, cout_q;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q;
  bit         q_valid = 1'b0;

  carry_select_4bit dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .F     (F),
    .cout  (cout),
    .F_q   (F_q),
    .cout_q(cout_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (A=%0d B=%0d cin=%0d rst=%0d)",
               name, act, exp, A, B, cin, rst);
    end
  endtask

  function automatic logic [4:0] model_sum(input logic [3:0] a, input logic [3:0] b, input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return s[4:0];
  endfunction

  // Model of the registered copy: what the flops must hold after each edge.
  always @(posedge clk) begin
    exp_q   = rst ? 5'd0 : model_sum(A, B, cin);
    q_valid = 1'b1;
  end

  always @(negedge clk) begin
    chk("comb_model", {cout, F}, model_sum(A, B, cin));
    if (q_valid) chk("reg_model", {cout_q, F_q}, exp_q);
  end

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(posedge clk);
    #2;
    A = a; B = b; cin = c;
  endtask

  initial begin
    // Reset held for two edges
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_q", {cout_q, F_q}, 5'b0_0000);

    // Register path after release
    @(negedge clk);
    rst = 1'b0; A = 4'd9; B = 4'd8; cin = 1'b0;
    @(posedge clk); #1;
    chk("reg_9p8", {cout_q, F_q}, 5'b1_0001);

    // Directed combinational boundaries
    drive(4'b1111, 4'b0000, 1'b1); #1;
    chk("wrap_all_blocks", {cout, F}, 5'b1_0000);
    drive(4'b0011, 4'b0001, 1'b0); #1;
    chk("blk0_carry_sel", {cout, F}, 5'b0_0100);
    drive(4'b1111, 4'b1111, 1'b1); #1;
    chk("max_value", {cout, F}, 5'b1_1111);
    drive(4'b0000, 4'b0000, 1'b0); #1;
    chk("all_zero", {cout, F}, 5'b0_0000);

    // Mid-run reset with A=7, B=5
    drive(4'd7, 4'd5, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_q", {cout_q, F_q}, 5'b0_1100);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_q", {cout_q, F_q}, 5'b0_0000);
    chk("midrst_comb", {cout, F}, 5'b0_1100);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_q", {cout_q, F_q}, 5'b0_1100);

    // Exhaustive sweep; the per-cycle compare process checks each vector
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          drive(4'(a), 4'(b), 1'(c));

    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
